// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scanner.
// Holds default geometry, the sequencer state encoding and colour constants.
package led_pkg;

    localparam int unsigned DEF_N_LEDS         = 64;
    localparam int unsigned DEF_RGB_W          = 24;
    localparam int unsigned DEF_ADDR_W         = 6;
    localparam int unsigned DEF_REFRESH_CYCLES = 50000;
    localparam int unsigned DEF_ACK_TIMEOUT    = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_RDY  = 3'd4,
        FRAME_END = 3'd5
    } state_t;

    localparam logic [23:0] RGB_OFF = 24'h000000;
    localparam logic [23:0] RGB_RED = 24'hFF0000;

    // Counter width that stays legal for degenerate (<=1) ranges.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_fb_bank.sv
// One frame-buffer bank: simple dual-port RAM, synchronous write and
// synchronous (registered) read. Contents are not reset.
module led_fb_bank #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/led_frame_scanner.sv
// Double-buffered LED frame store with a refresh sequencer that streams the
// front bank, one start/led_addr/rgb_data transaction per LED, to the SPI controller.
module led_frame_scanner
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS         = DEF_N_LEDS,
    parameter int unsigned RGB_W          = DEF_RGB_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              ready,
    output logic              start,
    output logic [ADDR_W-1:0] led_addr,
    output logic [RGB_W-1:0]  rgb_data,
    output logic              busy,
    output logic              frame_done,
    output logic              ack_err
);

    localparam int unsigned LAW   = clog2_min1(N_LEDS);
    localparam int unsigned TMR_W = clog2_min1(REFRESH_CYCLES);
    localparam int unsigned ACK_W = clog2_min1(ACK_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_LEDS - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [ACK_W-1:0]  ACK_MAX   = ACK_W'(ACK_TIMEOUT - 1);

    state_t             state_q, state_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [TMR_W-1:0]   tmr_q;
    logic               tmr_first_q;
    logic [ACK_W-1:0]   ack_cnt_q;
    logic               front_q;
    logic               swap_pending_q;
    logic               expired_c, do_swap_c, frame_go_c, ack_timeout_c, wr_ok_c;
    logic [RGB_W-1:0]   rdata0, rdata1;

    // Timer reads expired once saturated, and also straight out of reset.
    assign expired_c = tmr_first_q || (tmr_q == TMR_MAX);
    assign wr_ok_c   = wr_en && (32'(wr_addr) < N_LEDS);

    // Host writes go to the back bank; the read address leads the FSM by one
    // cycle so the pixel is ready to latch when leaving FETCH.
    led_fb_bank #(.DEPTH(N_LEDS), .WIDTH(RGB_W), .AW(LAW)) u_bank0 (
        .clk   (clk),
        .we    (wr_ok_c && front_q),
        .waddr (wr_addr[LAW-1:0]),
        .wdata (wr_data),
        .raddr (addr_n[LAW-1:0]),
        .rdata (rdata0)
    );

    led_fb_bank #(.DEPTH(N_LEDS), .WIDTH(RGB_W), .AW(LAW)) u_bank1 (
        .clk   (clk),
        .we    (wr_ok_c && !front_q),
        .waddr (wr_addr[LAW-1:0]),
        .wdata (wr_data),
        .raddr (addr_n[LAW-1:0]),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:      if (frame_go_c) state_n = FETCH;
            FETCH:     state_n = ISSUE;
            ISSUE:     state_n = WAIT_ACK;
            WAIT_ACK:  if (!ready || ack_timeout_c) state_n = WAIT_RDY;
            WAIT_RDY:  if (ready) state_n = (addr_q == LAST_ADDR) ? FRAME_END : FETCH;
            FRAME_END: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // A pending swap takes the IDLE cycle, so a frame never starts alongside it.
    always_comb begin
        do_swap_c     = 1'b0;
        frame_go_c    = 1'b0;
        ack_timeout_c = 1'b0;
        addr_n        = addr_q;
        case (state_q)
            IDLE: begin
                do_swap_c  = swap_pending_q;
                frame_go_c = enable && ready && expired_c && !swap_pending_q;
                if (frame_go_c) addr_n = '0;
            end
            WAIT_ACK: ack_timeout_c = ready && (ack_cnt_q == ACK_MAX);
            WAIT_RDY: if (ready && (addr_q != LAST_ADDR)) addr_n = addr_q + ADDR_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q         <= '0;
            tmr_q          <= '0;
            tmr_first_q    <= 1'b1;
            ack_cnt_q      <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack       <= 1'b0;
            ack_err        <= 1'b0;
            start          <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            led_addr       <= '0;
            rgb_data       <= RGB_W'(0);
        end else begin
            addr_q <= addr_n;
            if (frame_go_c) begin
                tmr_q       <= '0;
                tmr_first_q <= 1'b0;
            end else if (tmr_q != TMR_MAX) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end
            ack_cnt_q <= (state_q == WAIT_ACK) ? ack_cnt_q + ACK_W'(1) : '0;
            // A new request wins over clearing, so it survives into the next IDLE.
            if (swap_req)       swap_pending_q <= 1'b1;
            else if (do_swap_c) swap_pending_q <= 1'b0;
            if (do_swap_c) front_q <= ~front_q;
            swap_ack <= do_swap_c;
            if (ack_timeout_c) ack_err <= 1'b1;
            start      <= (state_n == ISSUE);
            busy       <= (state_n inside {FETCH, ISSUE, WAIT_ACK, WAIT_RDY});
            frame_done <= (state_n == FRAME_END);
            if (state_n == ISSUE) begin
                led_addr <= addr_q;
                rgb_data <= front_q ? rdata1 : rdata0;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_scanner.sv
// Directed bench for led_frame_scanner with a simple SPI-controller ready model.
module tb_led_frame_scanner;
    import led_pkg::*;

    localparam int unsigned N    = 64;
    localparam int unsigned AW   = 7;
    localparam int unsigned RW   = 24;
    localparam int unsigned REF  = 2000;
    localparam int unsigned ACKT = 16;
    localparam int unsigned MAXS = 2048;

    logic          clk = 1'b0;
    logic          rst, enable, wr_en, swap_req;
    logic          ready = 1'b1;
    logic          swap_ack, start, busy, frame_done, ack_err;
    logic [AW-1:0] wr_addr, led_addr;
    logic [RW-1:0] wr_data, rgb_data;

    always #5 clk = ~clk;

    led_frame_scanner #(
        .N_LEDS(N), .RGB_W(RW), .ADDR_W(AW), .REFRESH_CYCLES(REF), .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .ready(ready),
        .start(start), .led_addr(led_addr), .rgb_data(rgb_data), .busy(busy),
        .frame_done(frame_done), .ack_err(ack_err)
    );

    // Controller model: ready drops for ctl_low cycles after each accepted start.
    int unsigned ctl_low = 50;
    logic        ctl_hang = 1'b0;
    int unsigned ctl_cnt = 0;
    always @(posedge clk) begin
        if (ctl_hang) ready <= 1'b1;
        else if (start && ready) begin ready <= 1'b0; ctl_cnt <= ctl_low - 1; end
        else if (!ready) begin
            if (ctl_cnt == 0) ready <= 1'b1;
            else ctl_cnt <= ctl_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] st_addr [MAXS];
    logic [RW-1:0] st_rgb  [MAXS];
    int            st_cyc  [MAXS];
    int n_st = 0, fd_cnt = 0, fd_cyc = 0, sa_cnt = 0, sa_cyc = 0;
    always @(negedge clk) begin
        if (start && n_st < MAXS) begin
            st_addr[n_st] = led_addr; st_rgb[n_st] = rgb_data; st_cyc[n_st] = cyc;
            n_st++;
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (swap_ack)   begin sa_cnt++; sa_cyc = cyc; end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic nedge();
        @(negedge clk); #1;
    endtask

    function automatic logic [23:0] pat(input int sel, input int i);
        if (sel == 0) return (i % 9 == 0) ? RGB_RED : RGB_OFF;
        return {8'h00, 8'(i), 8'h5A};
    endfunction

    task automatic host_wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_fd(input int budget, output int at);
        int c0 = fd_cnt;
        int k = 0;
        at = -1;
        while (fd_cnt == c0 && k < budget) begin nedge(); k++; end
        if (fd_cnt == c0) begin
            checks++; errors++;
            $display("FAIL frame_done_timeout: got none expected pulse within %0d cycles", budget);
        end else at = fd_cyc;
    endtask

    task automatic wait_start(input logic [AW-1:0] a, input int budget);
        int k = 0;
        bit ok = 1'b0;
        while (!ok && k < budget) begin
            nedge(); k++;
            ok = start && (led_addr == a);
        end
        chk($sformatf("start_seen_addr%0d", a), 32'(ok), 32'd1);
    endtask

    task automatic chk_frame(input string name, input int base, input int sel);
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("%s addr[%0d]", name, i), 32'(st_addr[base+i]), 32'(i));
            chk($sformatf("%s rgb[%0d]", name, i), 32'(st_rgb[base+i]), 32'(pat(sel, i)));
        end
    endtask

    typedef struct packed {
        logic [6:0]  wr_addr;
        logic [23:0] wr_data;
        logic        swap_before;
        logic [5:0]  chk_addr;
        logic [23:0] exp_rgb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $fatal(1, "FAIL watchdog: simulation exceeded time limit");
    end

    initial begin
        int base, sa0, f1, f2, f3;

        // Writes into the back bank; one lands in the swap cycle, one after it.
        vecs[0] = '{7'd5,   24'h123456, 1'b0, 6'd5,  24'h123456};
        vecs[1] = '{7'd64,  24'hDEAD00, 1'b0, 6'd0,  24'hFF0000};
        vecs[2] = '{7'd100, 24'hBEEF01, 1'b0, 6'd36, 24'hFF0000};
        vecs[3] = '{7'd63,  24'h00ABCD, 1'b1, 6'd63, 24'h00ABCD};
        vecs[4] = '{7'd10,  24'h777777, 1'b0, 6'd10, 24'h000000};

        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        nedge();
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_led_addr", 32'(led_addr), 0);
        chk("rst_rgb", 32'(rgb_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_swap_ack", 32'(swap_ack), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        rst = 1'b0;

        // Pattern frame: red at every 9th LED, swapped in while disabled.
        for (int i = 0; i < int'(N); i++) host_wr(7'(i), pat(0, i));
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        repeat (3) tick();
        chk("t1_swap_ack_idle", 32'(sa_cnt), 1);
        base = n_st;
        enable = 1'b1;
        wait_fd(5000, f1);
        enable = 1'b0;
        chk("t1_busy_at_done", 32'(busy), 0);
        chk_frame("t1", base, 0);
        chk("t1_swap_before_start", 32'(sa_cyc < st_cyc[base]), 1);
        repeat (4) nedge();
        chk("t1_starts", 32'(n_st - base), 64);
        chk("t1_frames", 32'(fd_cnt), 1);
        chk("t1_swaps", 32'(sa_cnt), 1);
        chk("t1_ack_err", 32'(ack_err), 0);

        // Refresh period: fast controller, frames start exactly REF apart.
        ctl_low = 5;
        base = n_st;
        enable = 1'b1;
        wait_fd(3000, f1); wait_fd(3000, f2); wait_fd(3000, f3);
        enable = 1'b0;
        chk("t2_starts", 32'(n_st - base), 192);
        chk("t2_period1", 32'(st_cyc[base+64] - st_cyc[base]), REF);
        chk("t2_period2", 32'(st_cyc[base+128] - st_cyc[base+64]), REF);
        chk("t2_addr0", 32'(st_addr[base+128]), 0);

        // Back-to-back frames: frame longer than REF, single IDLE gap.
        ctl_low = 50;
        base = n_st;
        enable = 1'b1;
        wait_fd(5000, f1); wait_fd(5000, f2);
        enable = 1'b0;
        chk("t3_starts", 32'(n_st - base), 128);
        chk("t3_gap", 32'(st_cyc[base+64] - f1), 3);
        chk("t3_addr0", 32'(st_addr[base+64]), 0);

        // Swap requested at LED 30: only applied after the frame completes.
        for (int i = 0; i < int'(N); i++) host_wr(7'(i), pat(1, i));
        ctl_low = 5;
        sa0 = sa_cnt;
        base = n_st;
        enable = 1'b1;
        wait_start(7'd30, 3000);
        chk("t4_busy_mid", 32'(busy), 1);
        swap_req = 1'b1; nedge(); swap_req = 1'b0;
        wait_fd(3000, f1);
        chk("t4_no_swap_mid", 32'(sa_cnt - sa0), 0);
        wait_fd(3000, f2);
        enable = 1'b0;
        chk("t4_swap_once", 32'(sa_cnt - sa0), 1);
        chk("t4_swap_at", 32'(sa_cyc - f1), 2);
        chk_frame("t4_old", base, 0);
        chk_frame("t4_new", base + 64, 1);

        // Write table: out-of-range writes, swap-cycle write, post-swap write.
        sa0 = sa_cnt;
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].swap_before) begin
                swap_req = 1'b1; tick(); swap_req = 1'b0;
            end
            host_wr(vecs[v].wr_addr, vecs[v].wr_data);
        end
        base = n_st;
        enable = 1'b1;
        wait_fd(3000, f1);
        enable = 1'b0;
        chk("t5_swap_once", 32'(sa_cnt - sa0), 1);
        chk("t5_starts", 32'(n_st - base), 64);
        for (int v = 0; v < 5; v++)
            chk($sformatf("t5_vec%0d_rgb", v), 32'(st_rgb[base + int'(vecs[v].chk_addr)]),
                32'(vecs[v].exp_rgb));

        // Controller never acknowledges: ack_err after ACKT cycles, frame completes.
        ctl_hang = 1'b1;
        base = n_st;
        enable = 1'b1;
        wait_start(7'd0, 3000);
        chk("t6_ack_err_pre", 32'(ack_err), 0);
        repeat (16) nedge();
        chk("t6_ack_err_16", 32'(ack_err), 0);
        nedge();
        chk("t6_ack_err_17", 32'(ack_err), 1);
        wait_fd(3000, f1);
        enable = 1'b0;
        ctl_hang = 1'b0;
        chk("t6_starts", 32'(n_st - base), 64);
        chk("t6_led_period", 32'(st_cyc[base+1] - st_cyc[base]), 19);
        repeat (5) nedge();
        chk("t6_ack_err_sticky", 32'(ack_err), 1);

        // Reset mid-frame at LED 20, then a fresh frame from addr 0 of bank 0.
        ctl_low = 5;
        enable = 1'b1;
        wait_start(7'd20, 3000);
        #1 rst = 1'b1;
        #1;
        chk("t7_start_async", 32'(start), 0);
        chk("t7_busy_async", 32'(busy), 0);
        chk("t7_led_addr_async", 32'(led_addr), 0);
        chk("t7_rgb_async", 32'(rgb_data), 0);
        chk("t7_ack_err_async", 32'(ack_err), 0);
        nedge(); nedge();
        base = n_st;
        rst = 1'b0;
        wait_fd(3000, f1);
        enable = 1'b0;
        chk("t7_starts", 32'(n_st - base), 64);
        chk("t7_first_addr", 32'(st_addr[base]), 0);
        chk("t7_first_rgb", 32'(st_rgb[base]), 32'(pat(1, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
